// File: rtl/display_timing_pkg.sv
// Shared types and default raster timing for the display scan controller.
package display_timing_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam bit SYNC_POL_DEF = 1'b0;

    function automatic int h_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter; wrap flags the enabled cycle on which count returns to zero.
module wrap_counter #(
    parameter int MAX = 8,
    parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MAX - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/display_timing_ctrl.sv
// Raster scan controller: x/y wrap counters, blanking/sync decode and start/stop sequencing.
module display_timing_ctrl
    import display_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_done
);

    scan_state_e   state_reg, state_next;
    logic          x_en, x_wrap, y_en, y_wrap, cnt_clr;
    logic          start_ok, drain_end;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    assign x_en    = pix_ce && (state_reg != IDLE);
    assign y_en    = x_wrap && pix_ce;
    assign cnt_clr = (state_reg == IDLE);

    wrap_counter #(.MAX(H_TOTAL), .W(XW)) u_x_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (x_en),
        .clr   (cnt_clr),
        .count (x),
        .wrap  (x_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL), .W(YW)) u_y_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (y_en),
        .clr   (cnt_clr),
        .count (y),
        .wrap  (y_wrap)
    );

    // Mirror of the counters' next value so the registered decodes line up with x/y.
    always_comb begin
        x_next = x;
        y_next = y;
        if (cnt_clr) begin
            x_next = '0;
            y_next = '0;
        end else begin
            if (x_en) x_next = x_wrap ? '0 : x + 1'b1;
            if (y_en) y_next = y_wrap ? '0 : y + 1'b1;
        end
    end

    assign start_ok  = (state_reg == IDLE) && start && !stop;
    assign drain_end = (state_reg == DRAIN) && x_wrap && y_wrap;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)  state_next = RUN;
            RUN:     if (stop)      state_next = DRAIN;
            DRAIN:   if (drain_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            active      <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            busy        <= (state_next != IDLE);
            active      <= (state_next != IDLE)
                           && (32'(x_next) < H_ACTIVE) && (32'(y_next) < V_ACTIVE);
            hsync       <= ((32'(x_next) >= H_ACTIVE + H_FRONT)
                            && (32'(x_next) < H_ACTIVE + H_FRONT + H_SYNC)) ? SYNC_POL : !SYNC_POL;
            vsync       <= ((32'(y_next) >= V_ACTIVE + V_FRONT)
                            && (32'(y_next) < V_ACTIVE + V_FRONT + V_SYNC)) ? SYNC_POL : !SYNC_POL;
            // The wrap that ends a drained frame lands in IDLE, so it is not a new line.
            line_start  <= start_ok || (x_wrap && !drain_end);
            frame_start <= start_ok || ((state_reg == RUN) && x_wrap && y_wrap);
            frame_done  <= (state_next == DRAIN) && x_en
                           && (32'(x_next) == H_TOTAL - 1) && (32'(y_next) == V_TOTAL - 1);
        end
    end

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Directed bench for display_timing_ctrl on an 8x6 raster (H 4/1/2/1, V 3/1/1/1, active-low sync).
module tb_display_timing_ctrl;

    logic       clk = 1'b0;
    logic       reset, pix_ce, start, stop;
    logic       busy, active, hsync, vsync, line_start, frame_start, frame_done;
    logic [2:0] x, y;

    int vectors     = 0;
    int miscompares = 0;
    int p;

    always #5 clk = ~clk;

    display_timing_ctrl #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .x           (x),
        .y           (y),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected levels for the 8x6 raster: active x<4,y<3; hsync low at x=5,6; vsync low at y=4.
    task automatic chk_all(input string tag, input int ex, input int ey, input bit eb,
                           input bit els, input bit efs, input bit efd);
        bit ea, ehs, evs;
        ea  = eb && (ex < 4) && (ey < 3);
        ehs = !((ex == 5) || (ex == 6));
        evs = !(ey == 4);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".active"}, 32'(active), 32'(ea));
        chk({tag, ".hsync"}, 32'(hsync), 32'(ehs));
        chk({tag, ".vsync"}, 32'(vsync), 32'(evs));
        chk({tag, ".line_start"}, 32'(line_start), 32'(els));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(efs));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
        $display("%-6s t=%0t x=%0d y=%0d busy=%0b act=%0b hs=%0b vs=%0b ls=%0b fs=%0b fd=%0b",
                 tag, $time, x, y, busy, active, hsync, vsync, line_start, frame_start, frame_done);
    endtask

    initial begin
        reset = 1'b1; pix_ce = 1'b1; start = 1'b0; stop = 1'b0;

        // 1: reset held three cycles
        repeat (3) tick();
        chk_all("rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        // 2: start, continuous pix_ce, two full frames
        start = 1'b1;
        tick();
        start = 1'b0;
        p = 0;
        chk_all("start", 0, 0, 1, 1, 1, 0);
        for (int i = 1; i < 96; i++) begin
            tick();
            p = i % 48;
            chk_all("run", p % 8, p / 8, 1, (p % 8) == 0, p == 0, 0);
        end

        // 3: pix_ce alternating; raster advances every other cycle
        for (int k = 0; k < 96; k++) begin
            pix_ce = (k % 2 == 0);
            tick();
            if (k % 2 == 0) p = (p + 1) % 48;
            chk_all("ce", p % 8, p / 8, 1,
                    (k % 2 == 0) && (p % 8 == 0), (k % 2 == 0) && (p == 0), 0);
        end
        pix_ce = 1'b1;

        // 4: stop at (2,1), drain to (7,5); stray start/stop in DRAIN are ignored
        while (p != 10) begin
            tick();
            p = (p + 1) % 48;
            chk_all("to21", p % 8, p / 8, 1, (p % 8) == 0, p == 0, 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        p = p + 1;
        chk_all("stop", p % 8, p / 8, 1, 0, 0, 0);
        while (p < 47) begin
            if (p == 20) begin start = 1'b1; stop = 1'b1; end
            tick();
            start = 1'b0; stop = 1'b0;
            p = p + 1;
            chk_all("drain", p % 8, p / 8, 1, (p % 8) == 0, 0, p == 47);
        end
        tick();
        chk_all("done", 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("idle2", 0, 0, 0, 0, 0, 0);

        // 5: reset mid-frame at (3,2), then restart
        start = 1'b1;
        tick();
        start = 1'b0;
        p = 0;
        chk_all("rstrt", 0, 0, 1, 1, 1, 0);
        repeat (19) tick();
        p = 19;
        chk_all("at32", 3, 2, 1, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("mrst", 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("mrst2", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("again", 0, 0, 1, 1, 1, 0);
        tick();
        chk_all("again1", 1, 0, 1, 0, 0, 0);

        // 6: start+stop together in IDLE, then start mid-frame in RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_all("both", 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("both2", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("go", 0, 0, 1, 1, 1, 0);
        repeat (13) tick();
        chk_all("at51", 5, 1, 1, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("midst", 6, 1, 1, 0, 0, 0);
        tick();
        chk_all("midst1", 7, 1, 1, 0, 0, 0);
        tick();
        chk_all("midst2", 0, 2, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
